controlador_turnos_batalla: RTL and testbench

Game-flow controller for the 5x5 battleship board. It sequences placement and attack phases and alternates turns between player and PC. It enforces a per-turn timeout, issues registered cell-write strobes to the board, tracks remaining ship cells and declares win or loss. Its `colocar` output drives the board-matrix placement/attack selection.

---
 rtl/controlador_turnos_batalla_if.sv | 22 ++
 rtl/controlador_turnos_batalla.sv | 171 +++++++++++++++++
 tb/tb_controlador_turnos_batalla.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_turnos_batalla_if.sv
// Board-side bus of the battleship turn controller: player command and target cell in,
// registered cell-write strobe out.
interface controlador_turnos_batalla_if;
  logic       confirmar;
  logic [2:0] fila;
  logic [2:0] columna;
  logic [1:0] celda_valor;
  logic       escribir;
  logic [1:0] escribir_valor;
  logic [2:0] escribir_fila;
  logic [2:0] escribir_columna;

  modport master (
    input  confirmar, fila, columna, celda_valor,
    output escribir, escribir_valor, escribir_fila, escribir_columna
  );

  modport slave (
    output confirmar, fila, columna, celda_valor,
    input  escribir, escribir_valor, escribir_fila, escribir_columna
  );
endinterface

// File: rtl/controlador_turnos_batalla.sv
// Game-flow controller for the 5x5 battleship board: placement, alternating player/PC
// attack turns with a per-turn timeout, registered board writes and win/loss tracking.
module controlador_turnos_batalla #(
  parameter int BARCOS_MAX    = 5,
  parameter int TIMEOUT_TICKS = 15,
  parameter int ANCHO_TIMER   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iniciar,
  input  logic                   tick,
  input  logic [2:0]             num_barcos,
  input  logic                   pc_listo,
  input  logic                   pc_acierto,
  controlador_turnos_batalla_if.master tablero,
  output logic                   colocar,
  output logic                   turno_pc,
  output logic [ANCHO_TIMER-1:0] tiempo_restante,
  output logic [2:0]             restantes_jugador,
  output logic [2:0]             restantes_pc,
  output logic [2:0]             estado,
  output logic                   gano,
  output logic                   perdio
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COLOCAR   = 3'd1,
    TURNO_JUG = 3'd2,
    TURNO_PC  = 3'd3,
    FIN       = 3'd4
  } estado_t;

  localparam logic [2:0]             MAX_BARCOS = 3'(BARCOS_MAX);
  localparam logic [ANCHO_TIMER-1:0] TIMER_INI  = ANCHO_TIMER'(TIMEOUT_TICKS);
  localparam logic [ANCHO_TIMER-1:0] TIMER_UNO  = ANCHO_TIMER'(1);

  estado_t actual, siguiente;

  logic [2:0] barcos;
  logic [2:0] colocados;
  logic [2:0] n_clamp;
  logic [2:0] colocados_mas;
  logic [2:0] pc_rest_sig;
  logic [2:0] jug_rest_sig;
  logic       coord_ok;
  logic       conf_ok;
  logic       arranque;
  logic       coloca_ok;
  logic       ataque_ok;
  logic       ataque_acierto;
  logic       vence;
  logic       pc_jugada;

  logic       escr;
  logic [1:0] escr_valor;
  logic [2:0] escr_fila;
  logic [2:0] escr_columna;

  assign tablero.escribir         = escr;
  assign tablero.escribir_valor   = escr_valor;
  assign tablero.escribir_fila    = escr_fila;
  assign tablero.escribir_columna = escr_columna;

  // Qualified events; the decrement helpers saturate at zero so counters never wrap.
  always_comb begin
    n_clamp = num_barcos;
    if (num_barcos == 3'd0)
      n_clamp = 3'd1;
    else if (num_barcos > MAX_BARCOS)
      n_clamp = MAX_BARCOS;
    coord_ok       = (tablero.fila <= 3'd4) && (tablero.columna <= 3'd4);
    conf_ok        = tablero.confirmar && coord_ok;
    arranque       = iniciar && ((actual == IDLE) || (actual == FIN));
    coloca_ok      = (actual == COLOCAR) && conf_ok && (tablero.celda_valor == 2'd0);
    ataque_ok      = (actual == TURNO_JUG) && conf_ok && !tablero.celda_valor[1];
    ataque_acierto = ataque_ok && (tablero.celda_valor == 2'd1);
    vence          = (actual == TURNO_JUG) && tick && !ataque_ok &&
                     (tiempo_restante == TIMER_UNO);
    pc_jugada      = (actual == TURNO_PC) && pc_listo;
    colocados_mas  = colocados + 3'd1;
    pc_rest_sig    = (ataque_acierto && (restantes_pc != 3'd0)) ?
                     restantes_pc - 3'd1 : restantes_pc;
    jug_rest_sig   = (pc_acierto && (restantes_jugador != 3'd0)) ?
                     restantes_jugador - 3'd1 : restantes_jugador;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      actual <= IDLE;
    else
      actual <= siguiente;
  end

  always_comb begin
    siguiente = actual;
    case (actual)
      IDLE:      if (iniciar) siguiente = COLOCAR;
      COLOCAR:   if (coloca_ok && (colocados_mas == barcos)) siguiente = TURNO_JUG;
      TURNO_JUG: begin
        if (ataque_ok)
          siguiente = (pc_rest_sig == 3'd0) ? FIN : TURNO_PC;
        else if (vence)
          siguiente = TURNO_PC;
      end
      TURNO_PC:  if (pc_listo) siguiente = (jug_rest_sig == 3'd0) ? FIN : TURNO_JUG;
      FIN:       if (iniciar) siguiente = COLOCAR;
      default:   siguiente = IDLE;
    endcase
  end

  always_comb begin
    colocar  = (actual == COLOCAR);
    turno_pc = (actual == TURNO_PC);
    estado   = actual;
  end

  // Datapath: the write strobe defaults low so each accepted confirm yields a single pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      barcos            <= 3'd0;
      colocados         <= 3'd0;
      restantes_jugador <= 3'd0;
      restantes_pc      <= 3'd0;
      tiempo_restante   <= TIMER_INI;
      gano              <= 1'b0;
      perdio            <= 1'b0;
      escr              <= 1'b0;
      escr_valor        <= 2'd0;
      escr_fila         <= 3'd0;
      escr_columna      <= 3'd0;
    end else begin
      escr <= 1'b0;
      if (arranque) begin
        barcos            <= n_clamp;
        colocados         <= 3'd0;
        restantes_jugador <= n_clamp;
        restantes_pc      <= n_clamp;
        tiempo_restante   <= TIMER_INI;
        gano              <= 1'b0;
        perdio            <= 1'b0;
      end
      if (coloca_ok) begin
        escr         <= 1'b1;
        escr_valor   <= 2'd1;
        escr_fila    <= tablero.fila;
        escr_columna <= tablero.columna;
        colocados    <= colocados_mas;
      end
      if (ataque_ok) begin
        escr         <= 1'b1;
        escr_valor   <= ataque_acierto ? 2'd2 : 2'd3;
        escr_fila    <= tablero.fila;
        escr_columna <= tablero.columna;
        restantes_pc <= pc_rest_sig;
        if (pc_rest_sig == 3'd0)
          gano <= 1'b1;
      end else if ((actual == TURNO_JUG) && tick && (tiempo_restante > TIMER_UNO)) begin
        tiempo_restante <= tiempo_restante - TIMER_UNO;
      end
      if (pc_jugada) begin
        restantes_jugador <= jug_rest_sig;
        if (jug_rest_sig == 3'd0)
          perdio <= 1'b1;
        else
          tiempo_restante <= TIMER_INI;
      end
    end
  end

endmodule

// File: tb/tb_controlador_turnos_batalla.sv
// Directed self-checking bench for controlador_turnos_batalla with hand-computed expectations.
module tb_controlador_turnos_batalla;

  logic       clk = 1'b0;
  logic       rst;
  logic       iniciar;
  logic       tick;
  logic [2:0] num_barcos;
  logic       pc_listo;
  logic       pc_acierto;
  logic       colocar;
  logic       turno_pc;
  logic [3:0] tiempo_restante;
  logic [2:0] restantes_jugador;
  logic [2:0] restantes_pc;
  logic [2:0] estado;
  logic       gano;
  logic       perdio;

  int checks = 0;
  int errors = 0;
  int pulsos = 0;
  int pulsos_antes;

  controlador_turnos_batalla_if bus ();

  controlador_turnos_batalla #(
    .BARCOS_MAX(5),
    .TIMEOUT_TICKS(15),
    .ANCHO_TIMER(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .iniciar(iniciar),
    .tick(tick),
    .num_barcos(num_barcos),
    .pc_listo(pc_listo),
    .pc_acierto(pc_acierto),
    .tablero(bus.master),
    .colocar(colocar),
    .turno_pc(turno_pc),
    .tiempo_restante(tiempo_restante),
    .restantes_jugador(restantes_jugador),
    .restantes_pc(restantes_pc),
    .estado(estado),
    .gano(gano),
    .perdio(perdio)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.escribir === 1'b1)
      pulsos++;

  task automatic checkOutput(input string tag, input logic [31:0] observado,
                             input logic [31:0] esperado);
    checks++;
    if (observado !== esperado) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observado, esperado);
    end
  endtask

  // Drives one cycle of inputs, lets one rising edge pass, then samples 1 time unit later.
  task automatic applyStimulus(input logic ini, input logic tk, input logic conf,
                               input logic [2:0] f, input logic [2:0] c,
                               input logic [1:0] cv, input logic pl, input logic pa);
    iniciar         = ini;
    tick            = tk;
    bus.confirmar   = conf;
    bus.fila        = f;
    bus.columna     = c;
    bus.celda_valor = cv;
    pc_listo        = pl;
    pc_acierto      = pa;
    @(posedge clk);
    #1;
    iniciar       = 1'b0;
    tick          = 1'b0;
    bus.confirmar = 1'b0;
    pc_listo      = 1'b0;
    pc_acierto    = 1'b0;
  endtask

  task automatic checkWrite(input string tag, input logic [1:0] valor,
                            input logic [2:0] f, input logic [2:0] c);
    checkOutput({tag, "_escribir"}, 32'(bus.escribir), 32'd1);
    checkOutput({tag, "_valor"}, 32'(bus.escribir_valor), 32'(valor));
    checkOutput({tag, "_fila"}, 32'(bus.escribir_fila), 32'(f));
    checkOutput({tag, "_columna"}, 32'(bus.escribir_columna), 32'(c));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    iniciar = 1'b0; tick = 1'b0; num_barcos = 3'd0; pc_listo = 1'b0; pc_acierto = 1'b0;
    bus.confirmar = 1'b0; bus.fila = 3'd0; bus.columna = 3'd0; bus.celda_valor = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_estado", 32'(estado), 32'd0);
    checkOutput("rst_tiempo", 32'(tiempo_restante), 32'd15);
    checkOutput("rst_colocar", 32'(colocar), 32'd0);
    checkOutput("rst_escribir", 32'(bus.escribir), 32'd0);
    checkOutput("rst_flags", 32'({gano, perdio, turno_pc}), 32'd0);
    checkOutput("rst_restantes", 32'({restantes_jugador, restantes_pc}), 32'd0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] placement with two ships");
    num_barcos = 3'd2;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ini_estado", 32'(estado), 32'd1);
    checkOutput("ini_colocar", 32'(colocar), 32'd1);
    checkOutput("ini_rest_jug", 32'(restantes_jugador), 32'd2);
    checkOutput("ini_rest_pc", 32'(restantes_pc), 32'd2);
    applyStimulus(0, 0, 1, 1, 1, 1, 0, 0);
    checkOutput("occupied_no_write", 32'(bus.escribir), 32'd0);
    applyStimulus(0, 0, 1, 5, 0, 0, 0, 0);
    checkOutput("row5_no_write", 32'(bus.escribir), 32'd0);
    applyStimulus(0, 0, 1, 0, 5, 0, 0, 0);
    checkOutput("col5_no_write", 32'(bus.escribir), 32'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkWrite("place00", 2'd1, 3'd0, 3'd0);
    checkOutput("place00_estado", 32'(estado), 32'd1);
    applyStimulus(0, 0, 1, 4, 4, 0, 0, 0);
    checkWrite("place44", 2'd1, 3'd4, 3'd4);
    checkOutput("placed_estado", 32'(estado), 32'd2);
    checkOutput("placed_colocar", 32'(colocar), 32'd0);
    checkOutput("placed_tiempo", 32'(tiempo_restante), 32'd15);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("write_one_cycle", 32'(bus.escribir), 32'd0);

    $display("[TB] player timeout");
    pulsos_antes = pulsos;
    for (int k = 1; k <= 14; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("timer_run", 32'(tiempo_restante), 32'(15 - k));
    end
    checkOutput("timer_still_jug", 32'(estado), 32'd2);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("timeout_estado", 32'(estado), 32'd3);
    checkOutput("timeout_turno_pc", 32'(turno_pc), 32'd1);
    checkOutput("timeout_no_write", 32'(pulsos - pulsos_antes), 32'd0);
    applyStimulus(0, 1, 1, 2, 2, 1, 0, 0);
    checkOutput("pc_turn_conf_ignored", 32'(bus.escribir), 32'd0);
    checkOutput("pc_turn_rest_pc", 32'(restantes_pc), 32'd2);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("pc_miss_estado", 32'(estado), 32'd2);
    checkOutput("pc_miss_tiempo", 32'(tiempo_restante), 32'd15);
    checkOutput("pc_miss_rest_jug", 32'(restantes_jugador), 32'd2);

    $display("[TB] confirm together with final tick");
    for (int k = 1; k <= 14; k++)
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("last_tick_timer", 32'(tiempo_restante), 32'd1);
    applyStimulus(0, 1, 1, 2, 3, 0, 0, 0);
    checkWrite("conf_vs_tick", 2'd3, 3'd2, 3'd3);
    checkOutput("conf_vs_tick_estado", 32'(estado), 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("pc_hit_rest_jug", 32'(restantes_jugador), 32'd1);
    checkOutput("pc_hit_estado", 32'(estado), 32'd2);
    applyStimulus(0, 0, 1, 0, 0, 2, 0, 0);
    checkOutput("hit_cell_ignored", 32'(bus.escribir), 32'd0);
    checkOutput("hit_cell_estado", 32'(estado), 32'd2);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("timer_keeps_running", 32'(tiempo_restante), 32'd14);
    applyStimulus(0, 0, 1, 1, 2, 1, 0, 0);
    checkWrite("player_hit", 2'd2, 3'd1, 3'd2);
    checkOutput("player_hit_rest_pc", 32'(restantes_pc), 32'd1);
    checkOutput("player_hit_estado", 32'(estado), 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("lose_rest_jug", 32'(restantes_jugador), 32'd0);
    checkOutput("lose_estado", 32'(estado), 32'd4);
    checkOutput("lose_flags", 32'({gano, perdio}), 32'd1);
    applyStimulus(0, 1, 1, 0, 0, 1, 0, 0);
    checkOutput("fin_no_write", 32'(bus.escribir), 32'd0);
    checkOutput("fin_hold", 32'({estado, perdio}), 32'({3'd4, 1'b1}));

    $display("[TB] single ship, player wins");
    num_barcos = 3'd0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("clamp0_rest", 32'({restantes_jugador, restantes_pc}), 32'({3'd1, 3'd1}));
    checkOutput("restart_flags", 32'({gano, perdio}), 32'd0);
    checkOutput("restart_estado", 32'(estado), 32'd1);
    applyStimulus(0, 0, 1, 3, 3, 0, 0, 0);
    checkOutput("one_ship_estado", 32'(estado), 32'd2);
    applyStimulus(0, 0, 1, 4, 0, 1, 0, 0);
    checkWrite("win_hit", 2'd2, 3'd4, 3'd0);
    checkOutput("win_rest_pc", 32'(restantes_pc), 32'd0);
    checkOutput("win_estado", 32'(estado), 32'd4);
    checkOutput("win_flags", 32'({gano, perdio}), 32'd2);

    $display("[TB] single ship, player loses");
    num_barcos = 3'd1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 2, 2, 0, 0, 0);
    checkWrite("miss", 2'd3, 3'd2, 3'd2);
    checkOutput("miss_rest_pc", 32'(restantes_pc), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("lose1_rest_jug", 32'(restantes_jugador), 32'd0);
    checkOutput("lose1_flags", 32'({gano, perdio}), 32'd1);

    $display("[TB] clamp high and async reset");
    num_barcos = 3'd7;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("clamp7_rest_jug", 32'(restantes_jugador), 32'd5);
    applyStimulus(0, 0, 1, 2, 2, 0, 0, 0);
    num_barcos = 3'd1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("iniciar_ignored", 32'({estado, restantes_jugador}), 32'({3'd1, 3'd5}));
    applyStimulus(0, 0, 1, 0, 4, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 4, 0, 0, 0);
    applyStimulus(0, 0, 1, 2, 4, 0, 0, 0);
    checkOutput("four_placed_estado", 32'(estado), 32'd1);
    applyStimulus(0, 0, 1, 3, 4, 0, 0, 0);
    checkOutput("five_placed_estado", 32'(estado), 32'd2);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("pre_reset_tiempo", 32'(tiempo_restante), 32'd14);
    bus.confirmar = 1'b1; bus.fila = 3'd1; bus.columna = 3'd1; bus.celda_valor = 2'd0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_estado", 32'(estado), 32'd0);
    checkOutput("async_rst_tiempo", 32'(tiempo_restante), 32'd15);
    checkOutput("async_rst_flags", 32'({colocar, turno_pc, gano, perdio}), 32'd0);
    checkOutput("async_rst_rest", 32'({restantes_jugador, restantes_pc}), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("async_rst_write_dropped", 32'(bus.escribir), 32'd0);
    bus.confirmar = 1'b0;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_idle", 32'(estado), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
